// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel-rate strobe from a clock divider,
// h/v counters, and registered sync/blank/enable/coordinate outputs one pixel period behind the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 11
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  output logic          pix_stb,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // One extra bit so boundaries equal to 2^CW still compare correctly.
  localparam logic [CW:0] H_ACT_E = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYN_S = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYN_E = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_E = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYN_S = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYN_E = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = HS_POL[0];
  localparam logic VS_ACT = VS_POL[0];

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          stb;
  logic [CW:0]   h_ext, v_ext;

  logic          hblank_d, vblank_d, de_d, hs_d, vs_d, ls_d, fs_d;
  logic [CW-1:0] x_d, y_d;

  logic          pix_stb_q, hs_q, vs_q, de_q, hblank_q, vblank_q, ls_q, fs_q;
  logic [CW-1:0] x_q, y_q;

  always_comb begin
    stb     = (div_q == DIV_LAST);
    div_d   = stb ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (stb) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    h_ext    = {1'b0, h_cnt_q};
    v_ext    = {1'b0, v_cnt_q};
    hblank_d = (h_ext >= H_ACT_E);
    vblank_d = (v_ext >= V_ACT_E);
    de_d     = !hblank_d && !vblank_d;
    hs_d     = ((h_ext >= H_SYN_S) && (h_ext < H_SYN_E)) ? HS_ACT : ~HS_ACT;
    vs_d     = ((v_ext >= V_SYN_S) && (v_ext < V_SYN_E)) ? VS_ACT : ~VS_ACT;
    x_d      = hblank_d ? '0 : h_cnt_q;
    y_d      = vblank_d ? '0 : v_cnt_q;
    ls_d     = (h_cnt_q == '0);
    fs_d     = ls_d && (v_cnt_q == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pix_stb_q <= 1'b0;
      hs_q      <= ~HS_ACT;
      vs_q      <= ~VS_ACT;
      de_q      <= 1'b0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else if (!EN) begin
      div_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pix_stb_q <= 1'b0;
      hs_q      <= ~HS_ACT;
      vs_q      <= ~VS_ACT;
      de_q      <= 1'b0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      // The strobe is registered together with the decode, so it marks the
      // first CLK of the pixel period the outputs describe.
      div_q     <= div_d;
      pix_stb_q <= stb;
      if (stb) begin
        h_cnt_q  <= h_cnt_d;
        v_cnt_q  <= v_cnt_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        de_q     <= de_d;
        hblank_q <= hblank_d;
        vblank_q <= vblank_d;
        x_q      <= x_d;
        y_q      <= y_d;
        ls_q     <= ls_d;
        fs_q     <= fs_d;
      end
    end
  end

  assign pix_stb     = pix_stb_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign xpos        = x_q;
  assign ypos        = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster (CLK_DIV=1) checked cycle by cycle against a
// queued model, plus a default-horizontal raster (CLK_DIV=2) checked for strobe cadence, sync placement and frame length.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small raster: H 8/2/2/2 (14), V 4/1/1/1 (7), CLK_DIV=1
  logic        a_rst_n, a_en;
  logic        a_pix_stb, a_h_sync, a_v_sync, a_de, a_hblank, a_vblank, a_line_start, a_frame_start;
  logic [10:0] a_xpos, a_ypos;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(1), .CW(11)
  ) u_small (
    .CLK(clk), .RST_N(a_rst_n), .EN(a_en),
    .pix_stb(a_pix_stb), .h_sync(a_h_sync), .v_sync(a_v_sync), .de(a_de),
    .hblank(a_hblank), .vblank(a_vblank), .xpos(a_xpos), .ypos(a_ypos),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  // Default horizontal timing and divider; vertical shortened to 8 lines (sync on lines 5..6)
  logic        b_rst_n, b_en;
  logic        b_pix_stb, b_h_sync, b_v_sync, b_de, b_hblank, b_vblank, b_line_start, b_frame_start;
  logic [10:0] b_xpos, b_ypos;

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_full (
    .CLK(clk), .RST_N(b_rst_n), .EN(b_en),
    .pix_stb(b_pix_stb), .h_sync(b_h_sync), .v_sync(b_v_sync), .de(b_de),
    .hblank(b_hblank), .vblank(b_vblank), .xpos(b_xpos), .ypos(b_ypos),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {pix_stb, h_sync, v_sync, de, hblank, vblank, line_start, frame_start, xpos, ypos}
  localparam logic [29:0] A_IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0};

  function automatic logic [29:0] a_expect(input int h, input int v);
    logic        hb, vb;
    logic [10:0] x, y;
    hb = (h >= 8);
    vb = (v >= 4);
    x  = hb ? 11'd0 : 11'(h);
    y  = vb ? 11'd0 : 11'(v);
    return {1'b1, !((h >= 10) && (h < 12)), !(v == 5), (!hb && !vb), hb, vb,
            (h == 0), ((h == 0) && (v == 0)), x, y};
  endfunction

  function automatic logic [29:0] a_obs();
    return {a_pix_stb, a_h_sync, a_v_sync, a_de, a_hblank, a_vblank,
            a_line_start, a_frame_start, a_xpos, a_ypos};
  endfunction

  logic [29:0] sbq[$];
  int m_h, m_v, stb_n, phase;

  task automatic a_spot();
    if (phase == 0) begin
      if (stb_n == 0) begin
        check_eq("first_fs", a_frame_start, 1);
        check_eq("first_de", a_de, 1);
        check_eq("first_x", a_xpos, 0);
        check_eq("first_y", a_ypos, 0);
      end
      if (stb_n >= 1 && stb_n <= 7) check_eq("xpos_ramp", a_xpos, 32'(stb_n));
      if (stb_n == 8) begin
        check_eq("h8_de", a_de, 0);
        check_eq("h8_hblank", a_hblank, 1);
      end
      if (stb_n == 10 || stb_n == 11) check_eq("hsync_low", a_h_sync, 0);
      if (stb_n == 14) begin
        check_eq("line1_ls", a_line_start, 1);
        check_eq("line1_y", a_ypos, 1);
      end
      if (stb_n >= 70 && stb_n <= 83) check_eq("vsync_line5", a_v_sync, 0);
      if (stb_n == 98) check_eq("frame2_fs", a_frame_start, 1);
    end else if (stb_n == 0) begin
      check_eq(phase == 1 ? "en_ret_fs" : "rst_rel_fs", a_frame_start, 1);
      check_eq(phase == 1 ? "en_ret_x" : "rst_rel_x", a_xpos, 0);
      check_eq(phase == 1 ? "en_ret_y" : "rst_rel_y", a_ypos, 0);
    end
  endtask

  // Drive EN for the next edge, queue what that edge must produce, then compare.
  task automatic a_cycle(input logic en);
    logic [29:0] exp_w, got_w;
    a_en = en;
    if (en) begin
      sbq.push_back(a_expect(m_h, m_v));
      m_h++;
      if (m_h == 14) begin
        m_h = 0;
        m_v = (m_v + 1) % 7;
      end
    end else begin
      sbq.push_back(A_IDLE);
      m_h = 0;
      m_v = 0;
    end
    @(negedge clk);
    got_w = a_obs();
    exp_w = sbq.pop_front();
    check_eq("scoreboard", got_w, exp_w);
    if (a_pix_stb) begin
      a_spot();
      stb_n++;
    end
  endtask

  logic b_done;

  initial begin
    a_rst_n = 1'b0;
    a_en    = 1'b1;
    m_h = 0; m_v = 0; stb_n = 0; phase = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_idle", a_obs(), A_IDLE);
    a_rst_n = 1'b1;

    repeat (104) a_cycle(1'b1);
    check_eq("pre_drop_x", a_xpos, 5);
    repeat (3) begin
      a_cycle(1'b0);
      check_eq("en0_stb", a_pix_stb, 0);
      check_eq("en0_de", a_de, 0);
    end
    phase = 1; stb_n = 0;
    repeat (40) a_cycle(1'b1);

    #2 a_rst_n = 1'b0;
    #1 check_eq("arst_idle", a_obs(), A_IDLE);
    @(posedge clk);
    #1 check_eq("arst_hold", a_obs(), A_IDLE);
    @(negedge clk);
    a_rst_n = 1'b1;
    m_h = 0; m_v = 0; phase = 2; stb_n = 0;
    repeat (20) a_cycle(1'b1);

    for (int i = 0; i < 20000 && !b_done; i++) @(negedge clk);
    check_eq("b_done", b_done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  int   n_stb, hidx, line, hs_start, hs_len;
  logic prev_stb, vs_line, frame2;

  initial begin
    b_rst_n = 1'b0;
    b_en    = 1'b0;
    b_done  = 1'b0;
    frame2  = 1'b0;
    n_stb = 0; hidx = 0; line = 0; hs_start = -1; hs_len = 0;
    repeat (3) @(negedge clk);
    check_eq("b_rst_idle", {b_pix_stb, b_h_sync, b_v_sync, b_de, b_hblank, b_vblank}, 6'b011011);
    b_rst_n = 1'b1;
    b_en    = 1'b1;
    @(negedge clk);
    check_eq("b_no_early", b_pix_stb, 0);
    @(negedge clk);
    check_eq("b_first_stb", b_pix_stb, 1);
    check_eq("b_first_fs", b_frame_start, 1);
    check_eq("b_first_vs", b_v_sync, 1);
    prev_stb = b_pix_stb;
    vs_line  = b_v_sync;

    for (int c = 0; c < 14000 && !frame2; c++) begin
      @(negedge clk);
      if (c < 200) check_eq("b_toggle", b_pix_stb, !prev_stb);
      prev_stb = b_pix_stb;
      if (b_pix_stb) begin
        n_stb++;
        if (b_line_start) begin
          if (line == 0) begin
            check_eq("b_hs_start", 32'(hs_start), 656);
            check_eq("b_hs_len", 32'(hs_len), 96);
          end
          line++;
          hidx    = 0;
          vs_line = b_v_sync;
          check_eq("b_vs_line", b_v_sync, (line == 5 || line == 6) ? 0 : 1);
        end else begin
          hidx++;
          check_eq("b_vs_stable", b_v_sync, vs_line);
        end
        if (line == 0 && !b_h_sync) begin
          if (hs_len == 0) hs_start = hidx;
          hs_len++;
        end
        if (b_frame_start) begin
          check_eq("b_frame_len", 32'(n_stb), 800 * 8);
          frame2 = 1'b1;
        end
      end
    end
    check_eq("b_frame_seen", frame2, 1);
    b_done = 1'b1;
  end

endmodule
